// File: rtl/register_file.sv
// MIPS 32x32 general-purpose register file: one write port from writeback,
// two combinational read ports with same-cycle write-through, $0 hard-wired.
module register_file (
  input  logic        clock,
  input  logic        clear,
  input  logic        WE3,
  input  logic [4:0]  A3,
  input  logic [31:0] WD3,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WriteCount
);

  logic [31:0] regs_q [1:31];
  logic [31:0] count_q, count_d;
  logic        wr_acc;

  // Reset and $0 writes are both excluded here, so they neither store,
  // bypass, nor count.
  assign wr_acc = clear & WE3 & (A3 != 5'd0);

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    logic [31:0] v;
    v = '0;
    if (a != 5'd0) begin
      if (wr_acc && (A3 == a)) v = WD3;
      else                     v = regs_q[a];
    end
    return v;
  endfunction

  always_comb begin
    RD1 = rd_port(A1);
    RD2 = rd_port(A2);
  end

  always_comb begin
    count_d = count_q;
    if (wr_acc && (count_q != 32'hFFFF_FFFF)) count_d = count_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) regs_q[A3] <= WD3;
      count_q <= count_d;
    end
  end

  assign WriteCount = count_q;

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset sweep, writeback,
// $0 protection, bypass, reset collision and counter saturation.
module tb_register_file;

  logic        clock = 1'b0;
  logic        clear, WE3;
  logic [4:0]  A3, A1, A2;
  logic [31:0] WD3, RD1, RD2, WriteCount;

  int errors = 0;
  int checks = 0;

  register_file dut (
    .clock(clock), .clear(clear), .WE3(WE3), .A3(A3), .WD3(WD3),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WriteCount(WriteCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and checks happen mid-cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    WE3 = 1'b1; A3 = a; WD3 = d;
    tick();
    WE3 = 1'b0;
  endtask

  initial begin
    clear = 1'b0; WE3 = 1'b0; A3 = '0; WD3 = '0; A1 = '0; A2 = '0;
    tick();
    clear = 1'b1;
    #1;
    chk("reset_count", WriteCount, 32'd0);
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a); A2 = 5'(31 - a);
      #1;
      chk($sformatf("reset_rd1_r%0d", a), RD1, 32'd0);
      chk($sformatf("reset_rd2_r%0d", 31 - a), RD2, 32'd0);
    end

    // Write and read back
    wr(5'd8, 32'hDEAD_BEEF);
    wr(5'd31, 32'h1234_5678);
    A1 = 5'd8; A2 = 5'd31;
    #1;
    chk("rb_r8", RD1, 32'hDEAD_BEEF);
    chk("rb_r31", RD2, 32'h1234_5678);
    chk("rb_count", WriteCount, 32'd2);

    // $0 protection
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFF_FFFF; A1 = 5'd0; A2 = 5'd0;
    #1;
    chk("r0_same_cycle_rd1", RD1, 32'd0);
    chk("r0_same_cycle_rd2", RD2, 32'd0);
    tick();
    WE3 = 1'b0;
    #1;
    chk("r0_after_edge", RD1, 32'd0);
    chk("r0_count", WriteCount, 32'd2);

    // Bypass
    wr(5'd5, 32'h11);
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h22; A1 = 5'd5; A2 = 5'd5;
    #1;
    chk("byp_rd1", RD1, 32'h22);
    chk("byp_rd2", RD2, 32'h22);
    tick();
    WE3 = 1'b0;
    #1;
    chk("byp_after_rd1", RD1, 32'h22);
    chk("byp_after_rd2", RD2, 32'h22);
    chk("byp_count", WriteCount, 32'd4);

    // Write to a different address leaves reads unaffected
    WE3 = 1'b1; A3 = 5'd9; WD3 = 32'h99; A1 = 5'd8; A2 = 5'd31;
    #1;
    chk("diff_rd1", RD1, 32'hDEAD_BEEF);
    chk("diff_rd2", RD2, 32'h1234_5678);
    tick();
    WE3 = 1'b0; A1 = 5'd9;
    #1;
    chk("diff_r9", RD1, 32'h99);

    // Back-to-back writes, last edge wins
    wr(5'd7, 32'h1);
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h2; A1 = 5'd7;
    #1;
    chk("b2b_bypass", RD1, 32'h2);
    tick();
    WE3 = 1'b0;
    #1;
    chk("b2b_stored", RD1, 32'h2);
    chk("b2b_count", WriteCount, 32'd7);

    // Reset colliding with a write
    wr(5'd3, 32'hAA);
    clear = 1'b0; WE3 = 1'b1; A3 = 5'd3; WD3 = 32'h55; A1 = 5'd3; A2 = 5'd8;
    #1;
    chk("rst_coll_no_bypass", RD1, 32'hAA);
    tick();
    clear = 1'b1; WE3 = 1'b0;
    #1;
    chk("rst_coll_r3", RD1, 32'd0);
    chk("rst_coll_r8", RD2, 32'd0);
    chk("rst_coll_count", WriteCount, 32'd0);

    // Saturation from a preloaded counter
    dut.count_q = 32'hFFFF_FFFE;
    #1;
    chk("sat_preload", WriteCount, 32'hFFFF_FFFE);
    wr(5'd1, 32'h1);
    #1;
    chk("sat_w1", WriteCount, 32'hFFFF_FFFF);
    wr(5'd2, 32'h2);
    #1;
    chk("sat_w2", WriteCount, 32'hFFFF_FFFF);
    wr(5'd3, 32'h3);
    #1;
    chk("sat_w3", WriteCount, 32'hFFFF_FFFF);
    A1 = 5'd2; A2 = 5'd3;
    #1;
    chk("sat_r2", RD1, 32'h2);
    chk("sat_r3", RD2, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
# register_file

Architectural 32 x 32-bit MIPS general-purpose register file, the consumer at the far end of the writeback path. It accepts one write per cycle from the writeback stage (RegWriteW, WriteRegW and the selected result) and serves two combinational reads to the decode stage. A same-cycle write-through bypass lets decode see a value written in the same cycle. Register $0 is hard-wired to zero, and an accepted-write counter is exposed for verification.

## Interface
- No parameters. Geometry is fixed: 32 registers, 32 bits each, 5-bit addresses.
- clock  input  1  rising-edge clock for all state.
- clear  input  1  synchronous active-low reset; sampled on the rising clock edge.
- WE3  input  1  write enable, driven from RegWriteW bit 0.
- A3  input  5  write address, driven from WriteRegW.
- WD3  input  32  write data, the writeback result (ReadDataW or ALUOutW).
- A1  input  5  read port 1 address (rs).
- A2  input  5  read port 2 address (rt).
- RD1  output  32  read port 1 data.
- RD2  output  32  read port 2 data.
- WriteCount  output  32  number of accepted writes since reset; saturates.

## Operation
- Storage: regs[1..31], 32 bits each. regs[0] is not stored and always reads 0.
- Write acceptance:
  - A write is accepted when clear=1, WE3=1 and A3!=0.
  - On the rising edge, regs[A3] <= WD3.
  - A write with A3=0 is discarded and is not counted.
  - A write is ignored while clear=0.
- Read port n (n = 1, 2), combinational:
  - An=0 -> 0.
  - Otherwise, if a write is accepted this cycle and A3==An -> WD3 (bypass).
  - Otherwise -> regs[An].
- Both read ports are independent and may address the same register. Both may bypass in the same cycle.
- WriteCount:
  - Increments by 1 on each edge with an accepted write.
  - Holds at 32'hFFFF_FFFF; it never wraps.
- Reset: on an edge with clear=0, regs[1..31] <= 0 and WriteCount <= 0. Any write presented in that cycle is dropped.
- No other state exists.

## Timing
- Write latency: a value presented at edge k is readable from regs from edge k onward. Through the bypass it is visible combinationally in the cycle before edge k.
- Read latency: 0 cycles (combinational from A1/A2, A3, WE3, WD3, clear).
- Reset values:
  - RD1/RD2 = 0 for any address once reset has been applied, because all stored registers hold 0.
  - WriteCount = 0.
- Bypass is gated by clear=1. While clear=0, reads return stored contents without bypass.
- Before the first reset, contents are undefined (X in simulation). Benches must apply clear=0 for at least 1 edge.
- Reset mid-operation: a write and a reset in the same cycle leave the target register at 0.
- Back-to-back writes to the same address:
  - The last edge wins.
  - A read in the cycle of the second write sees the second WD3 through the bypass.
- Simultaneous write and reads to different addresses: reads return stored values and are unaffected.

## Test plan
- Reset then read: clear=0 for 1 edge, then sweep A1/A2 over 0..31 -> RD1=RD2=0 for every address, WriteCount=0.
- Write/readback: write 0xDEAD_BEEF to r8, then 0x1234_5678 to r31 -> next cycle A1=8 gives RD1=0xDEAD_BEEF, A2=31 gives RD2=0x1234_5678, WriteCount=2.
- $0 protection: WE3=1, A3=0, WD3=0xFFFF_FFFF -> RD1 with A1=0 is 0 both in the same cycle and after the edge, WriteCount unchanged.
- Bypass: r5 holds 0x11. Present WE3=1, A3=5, WD3=0x22 with A1=A2=5 -> RD1=RD2=0x22 before the edge. After the edge, with WE3=0, both still read 0x22.
- Reset collision: r3 holds 0xAA. Present WE3=1, A3=3, WD3=0x55 with clear=0 -> RD1 with A1=3 reads 0xAA (no bypass) during that cycle and 0 after the edge. WriteCount=0.
- Counter saturation: force 2^32 accepted writes, or preload the counter via a hierarchical deposit to 32'hFFFF_FFFE, then do 3 accepted writes -> WriteCount reads FFFF_FFFF and stays there.
